mod7_conv_ctrl: RTL
===================

Name: mod7_conv_ctrl

Overview:
- Sequential binary-to-residue converter controller for modulus 7.
- Accepts a WIDTH-bit binary operand over a valid/ready handshake. Walks its bits LSB-first and drives the shared mod-7 power-of-two lookup table (2^n mod 7) through lut_n / lut_val. Accumulates the residue modulo 7.
- Sits between the operand source and the RNS channel-7 datapath; one conversion in flight at a time.

Parameters:
- WIDTH, 32, operand bit width; legal range 1..32.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operand valid.
- in_ready, output, 1, controller can accept an operand.
- in_data, input, WIDTH, binary operand.
- lut_n, output, 32, bit index presented to the mod-7 LUT.
- lut_val, input, 32, LUT response (2^lut_n mod 7), combinational, same cycle.
- out_valid, output, 1, residue valid.
- out_ready, input, 1, consumer accepts residue.
- out_res, output, 3, residue in_data mod 7 (range 0..6).
- busy, output, 1, high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. All state clears immediately on assertion.
- Reset values:
  - state = IDLE, so in_ready = 1.
  - out_valid = 0, out_res = 0, lut_n = 0, busy = 0.
  - Internal shift register, index and accumulator = 0.
- States: IDLE, RUN, DONE. in_ready = (state == IDLE), decoded from state.
- IDLE:
  - On in_valid & in_ready at edge E0: load shift register with in_data, idx = 0, acc = 0, go to RUN.
- RUN:
  - lut_n = idx, zero-extended to 32 bits; held at 0 outside RUN.
  - Each edge: if shreg[0] = 1, then s = acc + lut_val[2:0] (4-bit); acc = (s >= 7) ? s - 7 : s.
  - Then shift shreg right by 1 and increment idx.
  - lut_val[31:3] are ignored. lut_val[2:0] = 7 contributes 0 through the same rule.
  - When the bit at idx = WIDTH-1 is processed, go to DONE on that edge.
  - Latency: out_valid is first high in the cycle after edge E0+WIDTH, i.e. WIDTH cycles after acceptance.
- DONE:
  - out_valid = 1; out_res = acc, held stable.
  - On out_valid & out_ready: go to IDLE, out_valid = 0. out_res retains its value until the next DONE.
  - out_ready may be high before out_valid; the handshake then completes in the first DONE cycle.
- Back-to-back operation: in_ready returns to 1 the cycle after the output handshake. There is no same-cycle input/output overlap.
- in_valid is ignored in RUN and DONE; in_data changes there have no effect.
- Reset mid-RUN or mid-DONE: conversion aborted, no out_valid is produced, the accumulator is discarded, and the block returns to IDLE.
- WIDTH = 1: a single RUN cycle, then DONE.

Optional Feature:
- Macro: MOD7_CONV_EARLY_EXIT_EN.
- Defined: in RUN, after processing bit idx, if the remaining shifted register (shreg >> 1) is 0, or idx = WIDTH-1, go to DONE on that edge.
  - Latency = (index of highest set bit) + 1.
  - in_data = 0 gives latency 1.
  - The residue value is identical to the non-early-exit result.
- Not defined: always exactly WIDTH RUN cycles. Latency is data-independent.

Test Plan:
1. WIDTH=32, in_data=10, out_ready=1 -> out_res=3; out_valid asserted exactly 32 cycles after the accept edge; lut_n steps 0..31 across RUN.
2. in_data=0xFFFFFFFF -> out_res=3; in_data=0x80000000 sent back-to-back after in_data=1 -> out_res 1, then 2; in_ready high the cycle after each output handshake.
3. out_ready held 0 for 5 cycles in DONE -> out_valid and out_res stable; in_ready=0; a pulsed in_valid with in_data=6 is not accepted.
4. rst_n pulsed low asynchronously (between edges) while idx=10 -> out_valid=0, busy=0, in_ready=1 immediately; a subsequent in_data=7 yields out_res=0 after 32 cycles.
5. LUT stub returning 32'hFFFF_FFF9 for every lut_n, in_data=3 -> only lut_val[2:0] used: 1+1 = 2 -> out_res=2.
6. With MOD7_CONV_EARLY_EXIT_EN: in_data=5 -> out_res=5, latency 3; in_data=0 -> out_res=0, latency 1. Without the macro, both cases take latency 32.

Source files
------------

// File: rtl/mod7_conv_ctrl.sv
// mod7_conv_ctrl: LSB-first binary-to-residue (mod 7) converter driving a shared 2^n mod 7 LUT.
// Optional MOD7_CONV_EARLY_EXIT_EN: finish as soon as no set bits remain.
module mod7_conv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [31:0]      lut_n,
    input  logic [31:0]      lut_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_res,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] shreg;
    logic [2:0] acc, acc_nxt;
    logic [3:0] s, d;
    logic last, unused_lut;
    assign unused_lut = ^lut_val[31:3];
    assign in_ready = state == IDLE;
    assign s = {1'b0, acc} + {1'b0, lut_val[2:0]};
    assign d = s - 4'd7;
    // a LUT response of 7 folds back to the same acc, i.e. contributes 0
    assign acc_nxt = shreg[0] ? (s >= 4'd7 ? d[2:0] : s[2:0]) : acc;
`ifdef MOD7_CONV_EARLY_EXIT_EN
    assign last = lut_n == 32'(WIDTH - 1) || (shreg >> 1) == '0;
`else
    assign last = lut_n == 32'(WIDTH - 1);
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            acc       <= '0;
            lut_n     <= '0;
            out_valid <= 1'b0;
            out_res   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    shreg <= in_data;
                    acc   <= '0;
                    lut_n <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    acc   <= acc_nxt;
                    shreg <= shreg >> 1;
                    lut_n <= last ? '0 : lut_n + 32'd1;
                    if (last) begin
                        out_res   <= acc_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
